// File: rtl/dice_arbiter.sv
// Round-robin arbiter sharing one dice module among four players.
// Presses the button, captures the settled face and keeps per-player totals.
module dice_arbiter #(
    parameter int ROLL_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [2:0] throw,
    output logic       dice_button,
    output logic [3:0] grant,
    output logic       busy,
    output logic       result_valid,
    output logic [2:0] result,
    output logic [1:0] result_player,
    output logic       bad_throw,
    output logic [7:0] score
);

    localparam logic [7:0] RC = 8'(ROLL_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ROLL,
        SETTLE,
        REPORT
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [7:0] cnt;
    logic [7:0] cnt_n;
    logic [1:0] last;
    logic [1:0] last_n;
    logic [1:0] owner;
    logic [1:0] owner_n;
    logic [7:0] total [4];

    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    logic [2:0] face;
    logic       face_bad;
    logic [8:0] sum;
    logic [7:0] sat;

    logic       button_n;
    logic [3:0] grant_n;
    logic       busy_n;
    logic       valid_n;
    logic       bad_n;
    logic [2:0] result_n;
    logic [1:0] player_n;
    logic [7:0] score_n;

    // search starts one past the last served player and wraps upward
    always_comb begin
        pick  = last + 2'd1;
        idx   = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        face_bad = (throw == 3'd0) || (throw == 3'd7);
        face     = face_bad ? 3'd1 : throw;
        sum      = {1'b0, total[owner]} + {6'd0, face};
        sat      = sum[8] ? 8'hFF : sum[7:0];
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last;
        owner_n = owner;
        unique case (state)
            IDLE: begin
                if (req != 4'd0) begin
                    state_n = ROLL;
                    owner_n = pick;
                    last_n  = pick;
                    cnt_n   = RC;
                end
            end
            ROLL: begin
                if (cnt == 8'd1) begin
                    state_n = SETTLE;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            SETTLE: state_n = REPORT;
            REPORT: state_n = IDLE;
        endcase
    end

    // output values for the coming cycle, derived from the next state
    always_comb begin
        button_n = (state_n == ROLL);
        busy_n   = (state_n != IDLE);
        grant_n  = busy_n ? (4'b0001 << owner_n) : 4'b0000;
        valid_n  = (state_n == REPORT);
        bad_n    = valid_n && face_bad;
        result_n = valid_n ? face : result;
        player_n = valid_n ? owner : result_player;
        score_n  = valid_n ? sat : score;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            last          <= 2'd3;
            owner         <= 2'd0;
            dice_button   <= 1'b0;
            grant         <= 4'd0;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
            bad_throw     <= 1'b0;
            result        <= 3'd0;
            result_player <= 2'd0;
            score         <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                total[i] <= 8'd0;
            end
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            last          <= last_n;
            owner         <= owner_n;
            dice_button   <= button_n;
            grant         <= grant_n;
            busy          <= busy_n;
            result_valid  <= valid_n;
            bad_throw     <= bad_n;
            result        <= result_n;
            result_player <= player_n;
            score         <= score_n;
            if (valid_n) begin
                total[owner] <= sat;
            end
        end
    end

endmodule

// File: tb/tb_dice_arbiter.sv
// Testbench for dice_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dice_arbiter;

    localparam int R = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [2:0] throw;
    logic       dice_button;
    logic [3:0] grant;
    logic       busy;
    logic       result_valid;
    logic [2:0] result;
    logic [1:0] result_player;
    logic       bad_throw;
    logic [7:0] score;

    logic [3:0] req1;
    logic       dice_button1;
    logic [3:0] grant1;
    logic       busy1;
    logic       result_valid1;
    logic [2:0] result1;
    logic [1:0] result_player1;
    logic       bad_throw1;
    logic [7:0] score1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    dice_arbiter #(.ROLL_CYCLES(R)) dut (
        .clk(clk), .rst(rst), .req(req), .throw(throw),
        .dice_button(dice_button), .grant(grant), .busy(busy),
        .result_valid(result_valid), .result(result),
        .result_player(result_player), .bad_throw(bad_throw),
        .score(score)
    );

    dice_arbiter #(.ROLL_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .throw(throw),
        .dice_button(dice_button1), .grant(grant1), .busy(busy1),
        .result_valid(result_valid1), .result(result1),
        .result_player(result_player1), .bad_throw(bad_throw1),
        .score(score1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // model: a roll is a transaction started at an arbitration edge;
    // outputs follow from the edge offset within that transaction
    bit       m_active = 0;
    int       m_start = 0;
    int       m_win = 0;
    int       m_last = 3;
    int       m_tot[4] = '{0, 0, 0, 0};
    logic     m_bad = 0;
    logic     e_button, e_busy, e_valid, e_bad;
    logic [3:0] e_grant;
    logic [2:0] e_result = 0;
    logic [1:0] e_player = 0;
    logic [7:0] e_score = 0;

    always @(posedge clk) begin
        int d;
        int f;
        cyc++;
        if (rst) begin
            m_active = 0;
            m_last   = 3;
            m_bad    = 0;
            m_tot    = '{0, 0, 0, 0};
            e_result = 0;
            e_player = 0;
            e_score  = 0;
        end else if (!m_active) begin
            if (req != 4'd0) begin
                for (int i = 1; i <= 4; i++) begin
                    if (!m_active && req[(m_last + i) % 4]) begin
                        m_win    = (m_last + i) % 4;
                        m_active = 1;
                    end
                end
                m_last  = m_win;
                m_start = cyc;
            end
        end else begin
            d = cyc - m_start;
            if (d == R + 1) begin
                f     = int'(throw);
                m_bad = (f == 0) || (f == 7);
                if (m_bad) f = 1;
                m_tot[m_win] = (m_tot[m_win] + f > 255) ? 255
                             : m_tot[m_win] + f;
                e_result = 3'(f);
                e_player = 2'(m_win);
                e_score  = 8'(m_tot[m_win]);
            end else if (d == R + 2) begin
                m_active = 0;
            end
        end
        if (m_active) begin
            d        = cyc - m_start;
            e_button = (d < R);
            e_busy   = 1'b1;
            e_grant  = 4'b0001 << m_win;
            e_valid  = (d == R + 1);
            e_bad    = e_valid && m_bad;
        end else begin
            e_button = 1'b0;
            e_busy   = 1'b0;
            e_grant  = 4'b0000;
            e_valid  = 1'b0;
            e_bad    = 1'b0;
        end
        #1;
        check("dice_button", 32'(dice_button), 32'(e_button));
        check("grant", 32'(grant), 32'(e_grant));
        check("busy", 32'(busy), 32'(e_busy));
        check("result_valid", 32'(result_valid), 32'(e_valid));
        check("bad_throw", 32'(bad_throw), 32'(e_bad));
        check("result", 32'(result), 32'(e_result));
        check("result_player", 32'(result_player), 32'(e_player));
        check("score", 32'(score), 32'(e_score));
    end

    bit         log_on = 0;
    logic [3:0] pg = 0;
    logic [3:0] gq[$];
    int         gc[$];

    always @(negedge clk) begin
        if (log_on) begin
            if (grant != 4'd0 && pg == 4'd0) begin
                gq.push_back(grant);
                gc.push_back(cyc);
            end
            pg = grant;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic roll(input logic [3:0] r, input logic [2:0] t,
                        output int nb, output int vat,
                        output logic [1:0] rp, output logic [2:0] res,
                        output logic [7:0] sc, output logic bad,
                        output logic [3:0] g1);
        @(negedge clk);
        req = r;
        throw = t;
        nb = 0; vat = 0; rp = 0; res = 0; sc = 0; bad = 0; g1 = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req = 4'd0;
                g1 = grant;
            end
            if (dice_button) nb++;
            if (result_valid && vat == 0) begin
                vat = i;
                rp  = result_player;
                res = result;
                sc  = score;
                bad = bad_throw;
            end
        end
    endtask

    initial begin
        int nb, vat, nv;
        logic [1:0] rp;
        logic [2:0] res;
        logic [7:0] sc;
        logic bad;
        logic [3:0] g1;
        logic [3:0] order[5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst = 1'b1;
        req = 4'd0;
        req1 = 4'd0;
        throw = 3'd1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_score", 32'(score), 0);
        check("rst_result", 32'(result), 0);

        roll(4'b0001, 3'd5, nb, vat, rp, res, sc, bad, g1);
        check("p0_grant", 32'(g1), 1);
        check("p0_button_cycles", 32'(nb), 8);
        check("p0_latency", 32'(vat), 10);
        check("p0_player", 32'(rp), 0);
        check("p0_score", 32'(sc), 5);

        roll(4'b0010, 3'd7, nb, vat, rp, res, sc, bad, g1);
        check("bad_grant", 32'(g1), 2);
        check("bad_result", 32'(res), 1);
        check("bad_flag", 32'(bad), 1);
        check("bad_score", 32'(sc), 1);

        @(negedge clk);
        req1 = 4'b0100;
        nb = 0; vat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req1 = 4'd0;
                check("r1_grant", 32'(grant1), 4);
            end
            if (dice_button1) nb++;
            if (result_valid1 && vat == 0) vat = i;
        end
        check("r1_button_cycles", 32'(nb), 1);
        check("r1_latency", 32'(vat), 3);

        for (int k = 1; k <= 44; k++) begin
            roll(4'b0100, 3'd6, nb, vat, rp, res, sc, bad, g1);
            if (k == 42) check("sat_252", 32'(sc), 252);
            if (k == 43) check("sat_255", 32'(sc), 255);
            if (k == 44) check("sat_hold", 32'(sc), 255);
        end

        do_reset();
        log_on = 1;
        @(negedge clk);
        req = 4'b1111;
        repeat (60) @(negedge clk);
        req = 4'd0;
        repeat (15) @(negedge clk);
        log_on = 0;
        check("rr_count_ok", 32'(gq.size() >= 5), 1);
        for (int i = 0; i < 5; i++) begin
            if (i < gq.size()) check("rr_order", 32'(gq[i]), 32'(order[i]));
            if (i > 0 && i < gc.size())
                check("rr_gap", 32'(gc[i] - gc[i-1]), R + 3);
        end

        do_reset();
        @(negedge clk);
        req = 4'b0001;
        throw = 3'd4;
        @(negedge clk);
        req = 4'd0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_button", 32'(dice_button), 0);
        check("abort_grant", 32'(grant), 0);
        check("abort_busy", 32'(busy), 0);
        nv = 0;
        repeat (12) begin
            @(negedge clk);
            if (result_valid) nv++;
        end
        check("abort_no_valid", 32'(nv), 0);
        check("abort_score", 32'(score), 0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            req   = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom_range(0, 15));
            throw = 3'($urandom_range(0, 7));
            rst   = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 4'd0;
        repeat (15) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
